// File: rtl/iq_multiport_fifo_if.sv
// rtl/iq_multiport_fifo_if.sv - push/pop bundle between fetch, decode and the instruction queue
interface iq_multiport_fifo_if #(
  parameter int INST_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 4
);
  logic                  push_valid;
  logic [INST_W-1:0]     push_inst;
  logic [ADDR_W-1:0]     push_pc;
  logic                  full;
  logic                  almost_full;
  logic                  overflow_err;
  logic [1:0]            pop_cnt;
  logic                  out0_valid;
  logic [INST_W-1:0]     out0_inst;
  logic [ADDR_W-1:0]     out0_pc;
  logic                  out1_valid;
  logic [INST_W-1:0]     out1_inst;
  logic [ADDR_W-1:0]     out1_pc;
  logic                  empty;
  logic [DEPTH_LOG2:0]   count;

  modport master (
    output push_valid, push_inst, push_pc, pop_cnt,
    input  full, almost_full, overflow_err,
    input  out0_valid, out0_inst, out0_pc,
    input  out1_valid, out1_inst, out1_pc,
    input  empty, count
  );

  modport slave (
    input  push_valid, push_inst, push_pc, pop_cnt,
    output full, almost_full, overflow_err,
    output out0_valid, out0_inst, out0_pc,
    output out1_valid, out1_inst, out1_pc,
    output empty, count
  );
endinterface

// File: rtl/iq_multiport_fifo.sv
// rtl/iq_multiport_fifo.sv - IF->ID instruction queue: 1 push, up to 2 pops per cycle
// Optional IQ_BYPASS_EN: push data appears on out0 in the same cycle when the queue is empty.
module iq_multiport_fifo #(
  parameter int INST_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_SLACK   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                clear,
  iq_multiport_fifo_if.slave  bus
);
  localparam int                  DEPTH   = 1 << DEPTH_LOG2;
  localparam int                  CW      = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = CW'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AF_C    = CW'(DEPTH - AF_SLACK);
  localparam logic [DEPTH_LOG2:0] ONE_C   = CW'(1);

  logic [INST_W-1:0]     mem_inst [DEPTH];
  logic [ADDR_W-1:0]     mem_pc   [DEPTH];
  logic [DEPTH_LOG2-1:0] head;
  logic [DEPTH_LOG2-1:0] tail;
  logic [DEPTH_LOG2-1:0] head_nx1;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  ovf;

  logic [1:0]            pop_req;
  logic [1:0]            pop_eff;
  logic                  is_full;
  logic                  is_empty;
  logic                  push_accept;
  logic                  bypass_hit;
  logic                  bypass_consume;

  always_comb begin
    is_full     = (cnt == DEPTH_C);
    is_empty    = (cnt == '0);
    pop_req     = (bus.pop_cnt == 2'd3) ? 2'd2 : bus.pop_cnt;
    // never retire more than is actually stored
    pop_eff     = (cnt < CW'(pop_req)) ? cnt[1:0] : pop_req;
    push_accept = bus.push_valid & ~is_full;
    head_nx1    = head + DEPTH_LOG2'(1);
`ifdef IQ_BYPASS_EN
    bypass_hit  = is_empty & bus.push_valid & rdy & ~clear;
`else
    bypass_hit  = 1'b0;
`endif
    bypass_consume = bypass_hit & (pop_req != 2'd0);
  end

  assign bus.count        = cnt;
  assign bus.full         = is_full;
  assign bus.almost_full  = (cnt >= AF_C);
  assign bus.empty        = is_empty;
  assign bus.overflow_err = ovf;
  assign bus.out0_valid   = ~is_empty | bypass_hit;
  assign bus.out0_inst    = bypass_hit ? bus.push_inst : mem_inst[head];
  assign bus.out0_pc      = bypass_hit ? bus.push_pc   : mem_pc[head];
  assign bus.out1_valid   = (cnt > ONE_C);
  assign bus.out1_inst    = mem_inst[head_nx1];
  assign bus.out1_pc      = mem_pc[head_nx1];

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else if (clear) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (rdy) begin
      if (bypass_consume) begin
        // entry handed straight to decode: both pointers step, nothing stored
        head <= head + DEPTH_LOG2'(1);
        tail <= tail + DEPTH_LOG2'(1);
      end else begin
        head <= head + DEPTH_LOG2'(pop_eff);
        if (push_accept)
          tail <= tail + DEPTH_LOG2'(1);
        cnt <= cnt + CW'(push_accept) - CW'(pop_eff);
      end
      if (bus.push_valid && is_full)
        ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && rdy && push_accept && !bypass_consume) begin
      mem_inst[tail] <= bus.push_inst;
      mem_pc[tail]   <= bus.push_pc;
    end
  end
endmodule
